coord_stack: RTL and testbench
==============================

Name: coord_stack

Overview:
- Parametrised LIFO register stack, the successor to the fixed 4-bit load register.
- Holds the maze path (packed {row,col} cells) so the solver controller can push on forward moves and pop on backtrack.
- Adds depth, push/pop/replace modes, occupancy count, full/empty status and sticky error flags.
- Sits between the maze-solver FSM (push/pop strobes) and the path-output logic (reads top of stack and count).

Parameters:
- WIDTH, 8, bits per entry (default packs 4-bit row and 4-bit col).
- DEPTH, 16, number of entries; must be at least 2.
- AW, 4, pointer width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low; resets state while 0.
- clr  input  1  synchronous clear of the stack and flags.
- push  input  1  write dataIn as the new top.
- pop  input  1  remove the top entry.
- dataIn  input  WIDTH  entry to push.
- dataOut  output  WIDTH  current top of stack; 0 when empty.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ovf  output  1  sticky: push attempted while full, without pop.
- udf  output  1  sticky: pop attempted while empty, without push.

Behaviour:
- Reset (rst=0, asynchronous): count=0, empty=1, full=0, ovf=0, udf=0, dataOut=0. Storage array is not reset.
- Registered state: all state updates on the rising clk edge. Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Read latency: dataOut = mem[count-1] when count>0, else 0. The effect of an operation is visible the cycle after its edge.
- Per-edge priority (highest first):
  1. clr=1: count<=0, ovf<=0, udf<=0. push and pop are ignored that cycle.
  2. push=1, pop=0, not full: mem[count]<=dataIn, count<=count+1.
  3. push=1, pop=0, full: no write, count unchanged, ovf<=1.
  4. push=0, pop=1, not empty: count<=count-1; the old top is left in storage.
  5. push=0, pop=1, empty: count unchanged, udf<=1.
  6. push=1, pop=1, not empty (replace top): mem[count-1]<=dataIn, count unchanged, no flag change. This is legal when full.
  7. push=1, pop=1, empty: treated as a plain push; count<=1, udf not set.
  8. No strobe: hold all state (the equivalent of ld=0 in the old register).
- Flags:
  - empty and full are pure decodes of count.
  - ovf and udf stay set until clr or rst.
  - Error cases never corrupt storage or count.
- Arithmetic: count never wraps. It saturates at DEPTH on push and at 0 on pop, via the guards above. The pointer index is count truncated to AW bits.
- Reset mid-operation: asserting rst while strobes are active takes effect immediately. The first edge after rst returns to 1 processes inputs normally.
- No internal state other than count, ovf, udf and storage. No FSM beyond the priority decode above.

Test Plan:
- Reset and idle: rst=0 then 1, no strobes for 3 cycles -> count=0, empty=1, full=0, dataOut=0x00, ovf=udf=0 throughout.
- Fill and overflow (DEPTH=16):
  - Push 0x10,0x11,...,0x1F on 16 cycles -> count=16, full=1, dataOut=0x1F.
  - A 17th push of 0xAA -> count=16, dataOut=0x1F, ovf=1.
- Drain and underflow: from the full state, pop 16 times -> dataOut steps 0x1E,...,0x10, then 0x00; empty=1. A 17th pop -> udf=1, count=0.
- Replace top: push 0x21 then 0x22, then push=pop=1 with dataIn=0x33 -> count=2, dataOut=0x33. One pop -> dataOut=0x21.
- Simultaneous on empty and on full:
  - push=pop=1 with dataIn=0x44 on an empty stack -> count=1, dataOut=0x44, udf=0.
  - Replace while full -> count=16, ovf unchanged.
- Clear priority and async reset:
  - With ovf=1 and count=5, assert clr together with push -> count=0, ovf=0, no write.
  - Drop rst mid-burst between clock edges -> count=0 immediately, before the next edge.

Source files
------------

// File: rtl/coord_stack.sv
`default_nettype none
// ============================================================================
// Module   : coord_stack
// Brief    : Parametrised LIFO register stack holding packed {row,col} maze
//            path cells. Supports push, pop, replace-top, occupancy count,
//            full/empty decode and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module coord_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_IDX_ONE  = AW'(1);

    // Stack storage; deliberately not reset, only count marks valid entries.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_udf;

    // Strobe decode and status derived from registered state.
    logic            w_empty;
    logic            w_full;
    logic            w_pushOnly;
    logic            w_popOnly;
    logic            w_both;
    logic            w_wrEn;
    logic [AW-1:0]   w_wrIdx;
    logic [AW-1:0]   w_topIdx;
    logic [AW-1:0]   w_cntIdx;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_pushOnly = push & ~pop;
    assign w_popOnly  = pop & ~push;
    assign w_both     = push & pop;

    // Pointer index is the count truncated to AW bits.
    assign w_cntIdx   = r_count[AW-1:0];
    assign w_topIdx   = w_cntIdx - c_IDX_ONE;

    // A write happens on a non-full push, on replace-top, or on a
    // simultaneous strobe against an empty stack (which acts as a push).
    assign w_wrEn     = ~clr & ((w_pushOnly & ~w_full) | w_both);

    // Replace-top overwrites the current top; every other write lands at count.
    assign w_wrIdx    = (w_both & ~w_empty) ? w_topIdx : w_cntIdx;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[w_wrIdx] <= dataIn;
        end
    end

    // Occupancy count and sticky error flags, in strict priority order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (w_pushOnly) begin
            if (w_full) begin
                r_ovf   <= 1'b1;
            end else begin
                r_count <= r_count + c_CNT_ONE;
            end
        end else if (w_popOnly) begin
            if (w_empty) begin
                r_udf   <= 1'b1;
            end else begin
                r_count <= r_count - c_CNT_ONE;
            end
        end else if (w_both) begin
            // Replace-top keeps the count; on an empty stack it is a push.
            if (w_empty) begin
                r_count <= c_CNT_ONE;
            end
        end
    end

    // Outputs decode registered state only; no input-to-output path.
    always_comb begin
        dataOut = '0;
        if (!w_empty) begin
            dataOut = r_mem[w_topIdx];
        end
    end

    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_coord_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_coord_stack
// Brief    : Directed, table-driven self-checking bench for coord_stack,
//            plus hand-written sequences for asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coord_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    int checks;
    int errors;

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] din;
        int         expCount;
        logic [7:0] expOut;
        logic       expOvf;
        logic       expUdf;
    } vec_t;

    vec_t vecs[$];

    coord_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .udf     (udf)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkAll(input int idx, input int expCount, input logic [7:0] expOut,
                            input logic expOvf, input logic expUdf);
        check("count",   idx, 32'(count),   32'(expCount));
        check("dataOut", idx, 32'(dataOut), 32'(expOut));
        check("empty",   idx, 32'(empty),   32'(expCount == 0));
        check("full",    idx, 32'(full),    32'(expCount == DEPTH));
        check("ovf",     idx, 32'(ovf),     32'(expOvf));
        check("udf",     idx, 32'(udf),     32'(expUdf));
    endtask

    function automatic void add(input logic pu, input logic po, input logic cl, input logic [7:0] d,
                                input int ec, input logic [7:0] eo, input logic eov, input logic eud);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.din = d;
        v.expCount = ec; v.expOut = eo; v.expOvf = eov; v.expUdf = eud;
        vecs.push_back(v);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clr    = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        dataIn = '0;

        // ---------------- vector table ----------------
        // Idle after reset.
        for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        // Fill with 0x10..0x1F.
        for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(8'h10 + i), i + 1, 8'(8'h10 + i), 0, 0);
        // Push while full: overflow, no change.
        add(1, 0, 0, 8'hAA, 16, 8'h1F, 1, 0);
        // Replace while full: top changes, ovf unchanged.
        add(1, 1, 0, 8'h5A, 16, 8'h5A, 1, 0);
        // Drain: 0x1E..0x10 then 0x00.
        for (int k = 1; k <= 16; k++)
            add(0, 1, 0, 8'h00, 16 - k, (k < 16) ? 8'(8'h1F - k) : 8'h00, 1, 0);
        // Pop while empty: underflow.
        add(0, 1, 0, 8'h00, 0, 8'h00, 1, 1);
        // Clear resets flags.
        add(0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        // Replace top sequence.
        add(1, 0, 0, 8'h21, 1, 8'h21, 0, 0);
        add(1, 0, 0, 8'h22, 2, 8'h22, 0, 0);
        add(1, 1, 0, 8'h33, 2, 8'h33, 0, 0);
        add(0, 1, 0, 8'h00, 1, 8'h21, 0, 0);
        add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        // Simultaneous strobes on empty act as a push, no udf.
        add(1, 1, 0, 8'h44, 1, 8'h44, 0, 0);
        add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        // Build ovf=1 with count=5: fill 0x60..0x6F, overflow, pop 11.
        for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(8'h60 + i), i + 1, 8'(8'h60 + i), 0, 0);
        add(1, 0, 0, 8'hBB, 16, 8'h6F, 1, 0);
        for (int k = 1; k <= 11; k++) add(0, 1, 0, 8'h00, 16 - k, 8'(8'h6F - k), 1, 0);
        // Clear together with push: clear wins.
        add(1, 0, 1, 8'hEE, 0, 8'h00, 0, 0);
        // Fresh push after clear lands at entry 0.
        add(1, 0, 0, 8'h77, 1, 8'h77, 0, 0);

        // ---------------- reset ----------------
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll(-1, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- apply table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            push   = vecs[i].push;
            pop    = vecs[i].pop;
            clr    = vecs[i].clr;
            dataIn = vecs[i].din;
            @(posedge clk);
            #1;
            checkAll(i, vecs[i].expCount, vecs[i].expOut, vecs[i].expOvf, vecs[i].expUdf);
        end

        // ---------------- async reset mid-burst ----------------
        @(negedge clk);
        push   = 1'b1;
        pop    = 1'b0;
        clr    = 1'b0;
        dataIn = 8'h90;
        @(posedge clk);
        #1;
        checkAll(1000, 2, 8'h90, 0, 0);
        // Drop rst between edges with push still active.
        #2;
        rst = 1'b0;
        #1;
        checkAll(1001, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        checkAll(1002, 0, 8'h00, 0, 0);
        // Release rst away from an edge; next edge pushes normally.
        @(negedge clk);
        rst    = 1'b1;
        dataIn = 8'h91;
        @(posedge clk);
        #1;
        checkAll(1003, 1, 8'h91, 0, 0);
        @(negedge clk);
        push = 1'b0;
        @(posedge clk);
        #1;
        checkAll(1004, 1, 8'h91, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
